fp_mul_iter: RTL and testbench
==============================

// Module: fp_mul_iter
// PURPOSE
//  Parametrised IEEE-754 floating-point multiplier: a single FSM-controlled datapath that
//  unpacks, multiplies significands with an iterative shift-add core, normalises, rounds
//  (round-to-nearest-even) and packs. It handles specials and reports exception flags.
//  Operands use a Start/Busy/Done handshake; sits between operand registers and the result bus.
// PARAMETERS
//  EXP_W   8   exponent field width; BIAS = 2**(EXP_W-1)-1 is derived (localparam)
//  MAN_W   23  stored fraction width; significand width SIG_W = MAN_W+1 (hidden bit)
// PORTS
//  CLK           in   1                 clock, all state changes on rising edge
//  Reset         in   1                 synchronous, active-high; wins over every other input
//  Start         in   1                 request; sampled only in IDLE
//  Multiplier    in   EXP_W+MAN_W+1     operand A {sign,exp,frac}; sampled with Start
//  Multiplicand  in   EXP_W+MAN_W+1     operand B; sampled with Start
//  Busy          out  1                 high in every state except IDLE
//  Done          out  1                 one-cycle pulse: Out/flags updated this cycle
//  Out           out  EXP_W+MAN_W+1     result; held from Done until the next Done
//  Overflow      out  1                 result rounded beyond max finite; held with Out
//  Underflow     out  1                 result below min normal, flushed to signed zero
//  Invalid       out  1                 inf*0 or any NaN operand
// BEHAVIOUR
//  Reset: state=IDLE; Busy=0, Done=0, Out=0, all flags=0; an in-flight product is discarded.
//  FSM: IDLE -> UNPACK -> MUL -> NORM -> ROUND -> DONE -> IDLE; UNPACK -> DONE on a special case.
//  IDLE: Start=1 latches both operands; Start while Busy=1 is ignored (no queueing).
//  UNPACK (1 cyc): sign=A.s^B.s; exp==0 -> zero (denormal inputs flushed to zero);
//    exp==all-ones -> inf (frac==0) or NaN. Special-case results:
//    NaN operand or inf*0 -> canonical qNaN {0,all-ones,1,0..0}, Invalid=1;
//    inf*finite-nonzero or inf*inf -> {sign,all-ones,0}; zero*finite -> {sign,0,0}; no flag.
//  MUL (SIG_W cycles): radix-2 shift-add over the two SIG_W-bit significands, giving a 2*SIG_W-bit product.
//  NORM (1 cyc): if product MSB set, shift right 1 and exp+1; form guard, round, sticky (OR of rest).
//    Exponent kept signed EXP_W+2 bits: e = eA + eB - BIAS (+1 from NORM).
//  ROUND (1 cyc): RNE; increment when G & (R|S|LSB). A mantissa carry-out sets frac=0 and exp+1.
//    exp >= all-ones -> {sign,all-ones,0}, Overflow=1; exp <= 0 -> {sign,0,0}, Underflow=1.
//  DONE (1 cyc): Done=1, Out/flags written; flags cleared at next Start acceptance.
//  Latency (Start-sampling edge = cycle 0): normal Done at cycle MAN_W+5 (28 default);
//    special case Done at cycle 2. Throughput: one op per latency+1 cycles (DONE->IDLE).
//  Start and Reset together: Reset wins, Start lost. Reset mid-MUL: no Done pulse is produced.
//  Exactly one flag or none per result; Done never asserted for two consecutive cycles.
// STRUCTURE
//  Package fp_mul_pkg: state encoding localparams (IDLE..DONE); a function returning
//    the canonical qNaN pattern for a given EXP_W/MAN_W; BIAS and SIG_W helpers.
//  Sub-module fp_sig_shiftadd (parameter SIG_W): start/done iterative unsigned multiplier.
//    Owns its bit counter and partial-product register. The top FSM waits on its done.
//  Top holds the FSM, unpack/special logic, normaliser, rounder, packer and output registers.
// TESTING
//  1) 0x3FC00000 * 0x40000000 (1.5*2) -> Out=0x40400000, flags 0, Done at cycle 28, Busy 1..28.
//  2) 0x3F800800 * 0x3F800800 (tie case, even LSB) -> Out=0x3F801000 (round down).
//  3) 0x7F000000 * 0x7F000000 -> Out=0x7F800000, Overflow=1;
//     0x00800000 * 0x00800000 -> Out=0x00000000, Underflow=1.
//  4) 0x7F800000 * 0x00000000 -> Out=0x7FC00000, Invalid=1, Done at cycle 2;
//     0xFF800000 * 0x40000000 -> 0xFF800000, no flag.
//  5) Reset at cycle 10 of an op -> Busy=0 next cycle, no Done. Then 0x40000000 * 0x40400000
//     -> 0x40C00000 at cycle 28. Start pulsed while Busy -> ignored, result unchanged.
//  6) EXP_W=5, MAN_W=10: 0x3C00 * 0x4000 (1*2) -> Out=0x4000, Done at cycle 15;
//     0x7800 * 0x7800 -> 0x7C00, Overflow=1.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the iterative floating-point multiplier: FSM states
// and format helpers (bias, significand width, canonical quiet NaN).
package fp_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_MUL    = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int sig_w_of(input int man_w);
        return man_w + 1;
    endfunction

    // {0, all-ones exponent, quiet bit set, rest zero}, right-aligned.
    function automatic logic [63:0] qnan_of(input int exp_w, input int man_w);
        logic [63:0] one;
        one = 64'd1;
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_sig_shiftadd.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, SIG_W
// cycles per product. 'done' is high during the cycle whose edge retires the last step.
module fp_sig_shiftadd
    import fp_mul_pkg::*;
#(
    parameter int SIG_W = 24
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 start,
    input  logic [SIG_W-1:0]     a,
    input  logic [SIG_W-1:0]     b,
    output logic                 done,
    output logic [2*SIG_W-1:0]   product
);

    localparam int CW = $clog2(SIG_W + 1);

    logic [SIG_W-1:0]   mcand_reg;
    logic [2*SIG_W-1:0] acc_reg;
    logic [CW-1:0]      count_reg;
    logic [SIG_W:0]     partial;

    // Upper half accumulates; the multiplier drains out of the lower half.
    assign partial = {1'b0, acc_reg[2*SIG_W-1:SIG_W]}
                   + (acc_reg[0] ? {1'b0, mcand_reg} : '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (start) begin
            mcand_reg <= a;
            acc_reg   <= {{SIG_W{1'b0}}, b};
            count_reg <= CW'(SIG_W);
        end else if (count_reg != '0) begin
            acc_reg   <= {partial, acc_reg[SIG_W-1:1]};
            count_reg <= count_reg - CW'(1);
        end
    end

    assign done    = (count_reg == CW'(1));
    assign product = acc_reg;

endmodule

// File: rtl/fp_mul_iter.sv
// IEEE-754 multiplier with denormal flush, RNE rounding and exception flags;
// Start/Busy/Done handshake around an iterative significand multiplier.
module fp_mul_iter
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [EXP_W+MAN_W:0]   Multiplier,
    input  logic [EXP_W+MAN_W:0]   Multiplicand,
    output logic                   Busy,
    output logic                   Done,
    output logic [EXP_W+MAN_W:0]   Out,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic                   Invalid
);

    localparam int FW    = EXP_W + MAN_W + 1;
    localparam int XW    = EXP_W + 2;
    localparam int BIAS  = bias_of(EXP_W);
    localparam int SIG_W = sig_w_of(MAN_W);
    localparam logic [FW-1:0]    QNAN     = FW'(qnan_of(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    state_t               state_reg;
    logic                 busy_reg, done_reg;
    logic [FW-1:0]        a_reg, b_reg, res_reg, out_reg;
    logic                 sign_reg;
    logic [XW-1:0]        exp_reg;
    logic [SIG_W-1:0]     mant_reg;
    logic                 guard_reg, round_reg, sticky_reg;
    logic                 ovf_pend_reg, unf_pend_reg, inv_pend_reg;
    logic                 ovf_reg, unf_reg, inv_reg;

    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 sign_ab, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                 special, invalid_case;
    logic [XW-1:0]        exp_sum;

    assign ea      = a_reg[FW-2 -: EXP_W];
    assign eb      = b_reg[FW-2 -: EXP_W];
    assign fa      = a_reg[MAN_W-1:0];
    assign fb      = b_reg[MAN_W-1:0];
    assign sign_ab = a_reg[FW-1] ^ b_reg[FW-1];
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == EXP_ONES) && (fa == '0);
    assign b_inf   = (eb == EXP_ONES) && (fb == '0);
    assign a_nan   = (ea == EXP_ONES) && (fa != '0);
    assign b_nan   = (eb == EXP_ONES) && (fb != '0);
    assign special      = a_zero | b_zero | (ea == EXP_ONES) | (eb == EXP_ONES);
    assign invalid_case = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    // Two spare bits keep both the sub-zero and the above-max range representable.
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - XW'(BIAS);

    logic                 mul_start, mul_done;
    logic [2*SIG_W-1:0]   product;

    assign mul_start = (state_reg == ST_UNPACK) && !special;

    fp_sig_shiftadd #(.SIG_W(SIG_W)) u_sig_mul (
        .clk     (CLK),
        .srst    (Reset),
        .start   (mul_start),
        .a       ({1'b1, fa}),
        .b       ({1'b1, fb}),
        .done    (mul_done),
        .product (product)
    );

    logic                 norm_hi, norm_g, norm_r, norm_s;
    logic [SIG_W-1:0]     norm_mant;

    assign norm_hi = product[2*SIG_W-1];

    always_comb begin
        if (norm_hi) begin
            norm_mant = product[2*SIG_W-1 -: SIG_W];
            norm_g    = product[SIG_W-1];
            norm_r    = product[SIG_W-2];
            norm_s    = |product[SIG_W-3:0];
        end else begin
            norm_mant = product[2*SIG_W-2 -: SIG_W];
            norm_g    = product[SIG_W-2];
            norm_r    = product[SIG_W-3];
            norm_s    = |product[SIG_W-4:0];
        end
    end

    logic                 round_up, rnd_ovf, rnd_unf;
    logic [SIG_W:0]       mant_sum;
    logic [XW-1:0]        exp_rnd;

    assign round_up = guard_reg & (round_reg | sticky_reg | mant_reg[0]);
    // On carry-out the low bits of mant_sum are already zero, so frac needs no fix-up.
    assign mant_sum = {1'b0, mant_reg} + (SIG_W+1)'(round_up);
    assign exp_rnd  = exp_reg + XW'(mant_sum[SIG_W]);
    assign rnd_ovf  = !exp_rnd[XW-1] && (exp_rnd[XW-2:0] >= {1'b0, EXP_ONES});
    assign rnd_unf  = exp_rnd[XW-1] || (exp_rnd == '0);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            out_reg      <= '0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            inv_reg      <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            res_reg      <= '0;
            sign_reg     <= 1'b0;
            exp_reg      <= '0;
            mant_reg     <= '0;
            guard_reg    <= 1'b0;
            round_reg    <= 1'b0;
            sticky_reg   <= 1'b0;
            ovf_pend_reg <= 1'b0;
            unf_pend_reg <= 1'b0;
            inv_pend_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        a_reg     <= Multiplier;
                        b_reg     <= Multiplicand;
                        busy_reg  <= 1'b1;
                        ovf_reg   <= 1'b0;
                        unf_reg   <= 1'b0;
                        inv_reg   <= 1'b0;
                        state_reg <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sign_reg     <= sign_ab;
                    ovf_pend_reg <= 1'b0;
                    unf_pend_reg <= 1'b0;
                    inv_pend_reg <= 1'b0;
                    if (special) begin
                        state_reg <= ST_DONE;
                        if (invalid_case) begin
                            res_reg      <= QNAN;
                            inv_pend_reg <= 1'b1;
                        end else if (a_inf || b_inf) begin
                            res_reg <= {sign_ab, EXP_ONES, {MAN_W{1'b0}}};
                        end else begin
                            res_reg <= {sign_ab, {(FW-1){1'b0}}};
                        end
                    end else begin
                        exp_reg   <= exp_sum;
                        state_reg <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_done) state_reg <= ST_NORM;
                end
                ST_NORM: begin
                    mant_reg   <= norm_mant;
                    guard_reg  <= norm_g;
                    round_reg  <= norm_r;
                    sticky_reg <= norm_s;
                    exp_reg    <= exp_reg + XW'(norm_hi);
                    state_reg  <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (rnd_ovf) begin
                        res_reg      <= {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
                        ovf_pend_reg <= 1'b1;
                    end else if (rnd_unf) begin
                        res_reg      <= {sign_reg, {(FW-1){1'b0}}};
                        unf_pend_reg <= 1'b1;
                    end else begin
                        res_reg <= {sign_reg, exp_rnd[EXP_W-1:0], mant_sum[MAN_W-1:0]};
                    end
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    out_reg   <= res_reg;
                    ovf_reg   <= ovf_pend_reg;
                    unf_reg   <= unf_pend_reg;
                    inv_reg   <= inv_pend_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = busy_reg;
    assign Done      = done_reg;
    assign Out       = out_reg;
    assign Overflow  = ovf_reg;
    assign Underflow = unf_reg;
    assign Invalid   = inv_reg;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: binary32 and binary16 instances, directed and random
// operands checked against an exact-arithmetic reference model.
module tb_fp_mul_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start32, start16;
    logic [31:0] a32, b32, out32;
    logic [15:0] a16, b16, out16;
    logic        busy32, done32, ovf32, unf32, inv32;
    logic        busy16, done16, ovf16, unf16, inv16;

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .CLK(clk), .Reset(rst), .Start(start32), .Multiplier(a32), .Multiplicand(b32),
        .Busy(busy32), .Done(done32), .Out(out32),
        .Overflow(ovf32), .Underflow(unf32), .Invalid(inv32)
    );

    fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
        .CLK(clk), .Reset(rst), .Start(start16), .Multiplier(a16), .Multiplicand(b16),
        .Busy(busy16), .Done(done16), .Out(out16),
        .Overflow(ovf16), .Underflow(unf16), .Invalid(inv16)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_out;
    logic [2:0]  last_flags;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Returns {special, invalid, underflow, overflow, result[31:0]}.
    function automatic logic [35:0] ref_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b);
        longint one, emask, fmask, ea, eb, fa, fb, p, q, rem, half, e, bias, r, s;
        int     k;
        bit     an, bn, ai, bi, az, bz, spec, ov, un, inv;
        one   = 1;
        emask = (one << ew) - 1;
        fmask = (one << mw) - 1;
        bias  = (one << (ew - 1)) - 1;
        s     = longint'(a[ew+mw] ^ b[ew+mw]);
        ea    = longint'(a >> mw) & emask;
        eb    = longint'(b >> mw) & emask;
        fa    = longint'(a) & fmask;
        fb    = longint'(b) & fmask;
        az = (ea == 0);  bz = (eb == 0);
        ai = (ea == emask) && (fa == 0);  bi = (eb == emask) && (fb == 0);
        an = (ea == emask) && (fa != 0);  bn = (eb == emask) && (fb != 0);
        spec = az || bz || ea == emask || eb == emask;
        ov = 0; un = 0; inv = 0;
        if (an || bn || (ai && bz) || (az && bi)) begin
            r = (emask << mw) | (one << (mw - 1));
            inv = 1;
        end else if (ai || bi) begin
            r = (s << (ew + mw)) | (emask << mw);
        end else if (az || bz) begin
            r = s << (ew + mw);
        end else begin
            p    = ((one << mw) | fa) * ((one << mw) | fb);
            k    = (p >= (one << (2 * mw + 1))) ? mw + 1 : mw;
            q    = p >> k;
            rem  = p - (q << k);
            half = one << (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (one << (mw + 1))) begin
                q = q >> 1;
                k = k + 1;
            end
            e = ea + eb - bias + longint'(k - mw);
            if (e >= emask) begin
                r  = (s << (ew + mw)) | (emask << mw);
                ov = 1;
            end else if (e <= 0) begin
                r  = s << (ew + mw);
                un = 1;
            end else begin
                r = (s << (ew + mw)) | (e << mw) | (q - (one << mw));
            end
        end
        return {spec, inv, un, ov, 32'(r)};
    endfunction

    function automatic logic [31:0] rand_op(input bit half);
        logic [31:0] r;
        int          mode;
        mode = $urandom_range(0, 5);
        r    = $urandom();
        if (!half) begin
            if (mode < 4) r[30:23] = 8'($urandom_range(96, 158));
        end else begin
            r[31:16] = 16'h0;
            if (mode < 4) r[14:10] = 5'($urandom_range(10, 20));
        end
        return r;
    endfunction

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done32 || done16) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit glitch);
        logic [35:0] exp_v;
        int          lat_exp, cyc, mw;
        bit          busy_ok, got;
        logic [31:0] o;
        logic [2:0]  fl;
        mw      = half ? 10 : 23;
        exp_v   = ref_mul(half ? 5 : 8, mw, a, b);
        lat_exp = exp_v[35] ? 2 : mw + 5;
        @(negedge clk);
        if (half) begin a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
        else      begin a32 = a;       b32 = b;       start32 = 1'b1; end
        @(posedge clk); #1;
        start16 = 1'b0; start32 = 1'b0;
        a32 = $urandom(); b32 = $urandom(); a16 = 16'($urandom()); b16 = 16'($urandom());
        busy_ok = 1; got = 0; cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!(half ? busy16 : busy32)) busy_ok = 0;
            if (glitch && c == 5) begin
                if (half) start16 = 1'b1; else start32 = 1'b1;
            end
            @(posedge clk); #1;
            start16 = 1'b0; start32 = 1'b0;
            if (half ? done16 : done32) begin got = 1; cyc = c; break; end
        end
        o  = half ? {16'h0, out16} : out32;
        fl = half ? {inv16, unf16, ovf16} : {inv32, unf32, ovf32};
        last_out = o; last_flags = fl;
        $display("op %s a=%h b=%h out=%h exp=%h flags=%b exp_flags=%b latency=%0d",
                 tag, a, b, o, exp_v[31:0], fl, exp_v[34:32], cyc);
        check({tag, " done_seen"}, got, 1);
        check({tag, " latency"}, cyc, lat_exp);
        check({tag, " busy_during"}, busy_ok, 1);
        check({tag, " busy_at_done"}, half ? busy16 : busy32, 0);
        check({tag, " out"}, o, exp_v[31:0]);
        check({tag, " flags"}, fl, exp_v[34:32]);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, half ? done16 : done32, 0);
        if (glitch) watch_no_done({tag, " no_queued_op"}, 35);
    endtask

    initial begin
        rst = 1'b1; start32 = 1'b0; start16 = 1'b0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        last_out = '0; last_flags = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset32", {busy32, done32, out32, ovf32, unf32, inv32}, 0);
        check("reset16", {busy16, done16, out16, ovf16, unf16, inv16}, 0);

        run_op(0, 32'h3FC00000, 32'h40000000, "t1_1p5x2", 0);
        check("t1 literal", {last_flags, last_out}, {3'b000, 32'h40400000});
        run_op(0, 32'h3F800800, 32'h3F800800, "t2_tie_even", 0);
        check("t2 literal", {last_flags, last_out}, {3'b000, 32'h3F801000});
        run_op(0, 32'h7F000000, 32'h7F000000, "t3_overflow", 0);
        check("t3a literal", {last_flags, last_out}, {3'b001, 32'h7F800000});
        run_op(0, 32'h00800000, 32'h00800000, "t3_underflow", 0);
        check("t3b literal", {last_flags, last_out}, {3'b010, 32'h00000000});
        run_op(0, 32'h7F800000, 32'h00000000, "t4_inf_x_zero", 0);
        check("t4a literal", {last_flags, last_out}, {3'b100, 32'h7FC00000});
        run_op(0, 32'hFF800000, 32'h40000000, "t4_neginf_x2", 0);
        check("t4b literal", {last_flags, last_out}, {3'b000, 32'hFF800000});

        // Reset sampled at cycle 10 of an op.
        @(negedge clk);
        a32 = 32'h3FC00000; b32 = 32'h40000000; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5 busy_after_reset", busy32, 0);
        check("t5 out_after_reset", out32, 0);
        rst = 1'b0;
        $display("op t5_reset_mid_mul busy=%b out=%h", busy32, out32);
        watch_no_done("t5 no_done_after_reset", 35);
        run_op(0, 32'h40000000, 32'h40400000, "t5_2x3", 0);
        check("t5 literal", {last_flags, last_out}, {3'b000, 32'h40C00000});
        run_op(0, 32'h3FC00000, 32'h40000000, "t5_start_while_busy", 1);
        check("t5 glitch literal", last_out, 32'h40400000);

        // Start and Reset on the same edge.
        @(negedge clk);
        a32 = 32'h40000000; b32 = 32'h40000000; start32 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; rst = 1'b0;
        check("start_with_reset busy", busy32, 0);
        $display("op start_with_reset busy=%b", busy32);
        watch_no_done("start_with_reset no_done", 35);

        run_op(1, 32'h3C00, 32'h4000, "t6_h_1x2", 0);
        check("t6a literal", {last_flags, last_out}, {3'b000, 32'h00004000});
        run_op(1, 32'h7800, 32'h7800, "t6_h_overflow", 0);
        check("t6b literal", {last_flags, last_out}, {3'b001, 32'h00007C00});

        for (int i = 0; i < 24; i++) run_op(0, rand_op(0), rand_op(0), $sformatf("rnd32_%0d", i), 0);
        for (int i = 0; i < 16; i++) run_op(1, rand_op(1), rand_op(1), $sformatf("rnd16_%0d", i), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
